// File: rtl/div_unit_hs.sv
// Iterative radix-4 restoring integer divider with valid/ready handshakes, tag pass-through,
// flush, resolved divide-by-zero / signed-overflow cases and optional leading-zero skipping.
module div_unit_hs #(
    parameter int WIDTH   = 32,
    parameter int ID_W    = 4,
    parameter int SKIP_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sign,
    input  logic [ID_W-1:0]  in_id,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic [WIDTH-1:0] out_r,
    output logic [ID_W-1:0]  out_id,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 2;
    localparam int PW = 2 * WIDTH + 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   p_q, p_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH+1:0]   b1_q, b1_d, b2_q, b2_d, b3_q, b3_d;
    logic [CW-1:0]      rem_q, rem_d;
    logic               neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [WIDTH-1:0]   res_quo_q, res_quo_d, res_rem_q, res_rem_d;
    logic [ID_W-1:0]    res_id_q, res_id_d;

    logic [PW-1:0]      pa_s, c16_s, c8_s, c4_s, b_ext_s, cand_s;
    logic [4:0]         sh_s;
    logic [WIDTH+1:0]   p4_s;
    logic [1:0]         digit_s;
    logic [WIDTH-1:0]   p_rad_s;
    logic [WIDTH-1:0]   step_p_s, step_a_s, step_quo_s;
    logic [CW-1:0]      step_rem_s;
    logic [WIDTH-1:0]   a_abs_s, b_abs_s;
    logic               div0_s, ovf_s;

    assign in_ready  = (state_q == IDLE) & ~flush;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_q     = res_quo_q;
    assign out_r     = res_rem_q;
    assign out_id    = res_id_q;

    // One iteration step: either a zero-digit skip of 16/8/4 bits or a radix-4 digit.
    always_comb begin
        pa_s    = {p_q, a_q, 16'h0000};
        c16_s   = pa_s >> WIDTH;
        c8_s    = pa_s >> (WIDTH + 8);
        c4_s    = pa_s >> (WIDTH + 12);
        b_ext_s = {{(WIDTH + 16){1'b0}}, b1_q[WIDTH-1:0]};
        sh_s    = 5'd0;
        cand_s  = c4_s;
        if ((SKIP_EN != 0) && (WIDTH > 16) && (rem_q >= CW'(16)) && (c16_s < b_ext_s)) begin
            sh_s   = 5'd16;
            cand_s = c16_s;
        end else if ((SKIP_EN != 0) && (rem_q >= CW'(8)) && (c8_s < b_ext_s)) begin
            sh_s   = 5'd8;
            cand_s = c8_s;
        end else if ((SKIP_EN != 0) && (rem_q >= CW'(4)) && (c4_s < b_ext_s)) begin
            sh_s   = 5'd4;
            cand_s = c4_s;
        end else begin
            sh_s   = 5'd0;
            cand_s = c4_s;
        end

        p4_s = {p_q, a_q[WIDTH-1:WIDTH-2]};
        if ({1'b0, p4_s} >= {1'b0, b3_q}) begin
            digit_s = 2'd3;
            p_rad_s = p4_s[WIDTH-1:0] - b3_q[WIDTH-1:0];
        end else if ({1'b0, p4_s} >= {1'b0, b2_q}) begin
            digit_s = 2'd2;
            p_rad_s = p4_s[WIDTH-1:0] - b2_q[WIDTH-1:0];
        end else if ({1'b0, p4_s} >= {1'b0, b1_q}) begin
            digit_s = 2'd1;
            p_rad_s = p4_s[WIDTH-1:0] - b1_q[WIDTH-1:0];
        end else begin
            digit_s = 2'd0;
            p_rad_s = p4_s[WIDTH-1:0];
        end

        if (sh_s != 5'd0) begin
            step_p_s   = cand_s[WIDTH-1:0];
            step_a_s   = a_q << sh_s;
            step_quo_s = quo_q << sh_s;
            step_rem_s = rem_q - CW'(sh_s);
        end else begin
            step_p_s   = p_rad_s;
            step_a_s   = a_q << 2;
            step_quo_s = {quo_q[WIDTH-3:0], digit_s};
            step_rem_s = rem_q - CW'(2);
        end
    end

    // Operand magnitudes and special-case detection at accept time.
    always_comb begin
        a_abs_s = (in_sign & in_a[WIDTH-1]) ? (-in_a) : in_a;
        b_abs_s = (in_sign & in_b[WIDTH-1]) ? (-in_b) : in_b;
        div0_s  = (in_b == {WIDTH{1'b0}});
        ovf_s   = in_sign & (in_a == {1'b1, {(WIDTH-1){1'b0}}}) & (in_b == {WIDTH{1'b1}});
    end

    // Next-state and datapath control; flush overrides every transition.
    always_comb begin
        state_d   = state_q;
        p_d       = p_q;
        a_d       = a_q;
        quo_d     = quo_q;
        b1_d      = b1_q;
        b2_d      = b2_q;
        b3_d      = b3_q;
        rem_d     = rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        id_d      = id_q;
        res_quo_d = res_quo_q;
        res_rem_d = res_rem_q;
        res_id_d  = res_id_q;
        case (state_q)
            IDLE: begin
                if (in_valid & in_ready) begin
                    neg_quo_d = in_sign & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                    neg_rem_d = in_sign & in_a[WIDTH-1];
                    p_d       = {WIDTH{1'b0}};
                    a_d       = a_abs_s;
                    quo_d     = {WIDTH{1'b0}};
                    b1_d      = {2'b00, b_abs_s};
                    b2_d      = {1'b0, b_abs_s, 1'b0};
                    b3_d      = {2'b00, b_abs_s} + {1'b0, b_abs_s, 1'b0};
                    rem_d     = CW'(WIDTH);
                    id_d      = in_id;
                    if (div0_s) begin
                        res_quo_d = {WIDTH{1'b1}};
                        res_rem_d = in_a;
                        res_id_d  = in_id;
                        state_d   = DONE;
                    end else if (ovf_s) begin
                        res_quo_d = in_a;
                        res_rem_d = {WIDTH{1'b0}};
                        res_id_d  = in_id;
                        state_d   = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                p_d   = step_p_s;
                a_d   = step_a_s;
                quo_d = step_quo_s;
                rem_d = step_rem_s;
                if (step_rem_s == {CW{1'b0}}) begin
                    res_quo_d = neg_quo_q ? (-step_quo_s) : step_quo_s;
                    res_rem_d = neg_rem_q ? (-step_p_s) : step_p_s;
                    res_id_d  = id_q;
                    state_d   = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (flush) begin
            state_d = IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            p_q       <= {WIDTH{1'b0}};
            a_q       <= {WIDTH{1'b0}};
            quo_q     <= {WIDTH{1'b0}};
            b1_q      <= {(WIDTH + 2){1'b0}};
            b2_q      <= {(WIDTH + 2){1'b0}};
            b3_q      <= {(WIDTH + 2){1'b0}};
            rem_q     <= {CW{1'b0}};
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            id_q      <= {ID_W{1'b0}};
            res_quo_q <= {WIDTH{1'b0}};
            res_rem_q <= {WIDTH{1'b0}};
            res_id_q  <= {ID_W{1'b0}};
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            a_q       <= a_d;
            quo_q     <= quo_d;
            b1_q      <= b1_d;
            b2_q      <= b2_d;
            b3_q      <= b3_d;
            rem_q     <= rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            id_q      <= id_d;
            res_quo_q <= res_quo_d;
            res_rem_q <= res_rem_d;
            res_id_q  <= res_id_d;
        end
    end

endmodule
